adsr_vca: RTL and testbench
===========================

Name: adsr_vca

Overview:
- Envelope-and-amplitude stage directly downstream of waveform_generators.
- Runs an ADSR envelope state machine driven by a note gate and per-stage rates.
- Scales the selected 8-bit waveform sample (offset-binary, 0x80 = zero) by the envelope and emits an 8-bit offset-binary sample for the output mixer/PWM.
- Envelope timing advances only on sample ticks (enable); gate handling is evaluated every clock.

Parameters:
- ACC_W, 20, envelope accumulator width (≥10). env_out is acc[ACC_W-1:ACC_W-8].

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- enable  in  1  sample tick; rate stepping occurs only when 1.
- gate  in  1  note gate, level-sensitive.
- attack_rate  in  8  attack step = attack_rate+1 per tick.
- decay_rate  in  8  decay step = decay_rate+1 per tick.
- sustain_level  in  8  sustain level.
- release_rate  in  8  release step = release_rate+1 per tick.
- wave_in  in  8  waveform sample from waveform_generators (offset-binary).
- env_out  out  8  current envelope level.
- audio_out  out  8  scaled sample (offset-binary).
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- busy  out  1  env_state != IDLE.

Behaviour:
- Reset (rst=1 at clk edge): acc=0, state=IDLE, gate_q=0, env_out=0x00, audio_out=0x80, busy=0.
- gate_q registers gate every clk. rise = gate & ~gate_q.
- Per-clock priority:
  1. rise: state←ATTACK. acc is kept, so retrigger is legato from the current level. This applies from any state, including RELEASE and ATTACK.
  2. else if gate=0 and state ∈ {ATTACK, DECAY, SUSTAIN}: state←RELEASE, acc unchanged.
  3. else if enable: rate step per state, below.
  4. No rate step occurs in a cycle where 1 or 2 fires.
- Definitions: MAX = all ones (ACC_W bits). TGT = {sustain_level, (ACC_W-8) ones}. Step arithmetic uses ACC_W+1 bits, so there is no wrap.
- ATTACK: if acc+step ≥ MAX, then acc←MAX and state←DECAY; else acc←acc+step.
- DECAY: if acc ≤ TGT+step, then acc←TGT and state←SUSTAIN; else acc←acc−step.
  - Covers sustain_level=0xFF: exits on the first tick.
  - Covers acc already below TGT: jumps up to TGT.
- SUSTAIN: acc←TGT on every tick, so sustain_level changes track live.
- RELEASE: if acc ≤ step, then acc←0 and state←IDLE; else acc←acc−step.
- IDLE: acc held at 0. A rise with gate still 1 is required to leave IDLE; a gate held high through reset release does count as a rise.
- Rate register changes take effect on the next tick; no latching.
- env_out = acc top 8 bits, registered (same cycle as acc).
- VCA path, registered, latency 1 clk from wave_in/env_out:
  - s = wave_in − 128 (signed 9-bit).
  - p = s × env_out (signed 17-bit).
  - audio_out ← 128 + (p >>> 8), arithmetic shift, floor.
  - Result range is 0..254. env_out=0 gives 0x80.
  - Updates every clk, independent of enable.
- rst asserted mid-note: everything returns to reset values on that edge; no release tail.

Decomposition:
- Shared package adsr_pkg: state encoding constants (IDLE..RELEASE, 3-bit), midscale constant 8'h80.
- One sub-module vca_scale: combinational signed scale of wave_in by env_out. The output register stays in adsr_vca.
- State machine and accumulator stay in the top module.

Test Plan:
- Run all scenarios with ACC_W=10 and enable=1 continuously.
- Attack: reset, gate 0→1, attack_rate=0x3F (step 64) -> ATTACK for 16 ticks. Tick 16 clamps acc=0x3FF, env_out=0xFF, env_state=2.
- Decay/sustain: continue with decay_rate=0xFF (step 256), sustain=0x80 -> acc 0x2FF, then clamp to 0x203, env_state=3, env_out=0x80. Change sustain to 0x40 -> next tick env_out=0x40.
- Release: from sustain 0x80, drop gate, release_rate=0x7F (step 128) -> RELEASE next clk. acc 387, 259, 131, 3, then 0, env_state=0, busy=0.
- Retrigger mid-release: at acc=259, raise gate -> ATTACK with acc=259 (no reset to 0). Next tick acc=259+attack step.
- VCA: env_out=0xFF; wave_in=0xFF -> audio_out=0xFE one clk later; wave_in=0x00 -> 0x00; wave_in=0x80 -> 0x80. With env_out=0, any wave_in -> 0x80.
- Reset mid-attack: assert rst at acc≈500 -> next edge env_out=0, audio_out=0x80, env_state=0. Gate held high across release of rst -> ATTACK begins.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared definitions for the ADSR envelope / VCA stage.
package adsr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [7:0] MIDSCALE = 8'h80;

endpackage

// File: rtl/vca_scale.sv
// Combinational signed scaling of an offset-binary sample by an envelope.
module vca_scale
    import adsr_pkg::*;
(
    input  logic [7:0] wave,
    input  logic [7:0] env_level,
    output logic [7:0] scaled
);

    logic signed [8:0]  s;
    logic signed [8:0]  e;
    logic signed [16:0] p;

    assign s = $signed({1'b0, wave}) - 9'sd128;
    assign e = $signed({1'b0, env_level});
    assign p = s * e;

    // p >>> 8 spans -128..126, so its low byte re-centred on midscale is exact
    assign scaled = MIDSCALE + p[15:8];

    logic unused_bits;
    assign unused_bits = &{1'b0, p[16], p[7:0]};

endmodule

// File: rtl/adsr_vca.sv
// ADSR envelope generator driving a registered VCA on the waveform sample.
module adsr_vca
    import adsr_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       gate,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_rate,
    input  logic [7:0] wave_in,
    output logic [7:0] env_out,
    output logic [7:0] audio_out,
    output logic [2:0] env_state,
    output logic       busy
);

    localparam int EW = ACC_W + 1;

    env_state_t       state, state_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic             gate_q;
    logic             rise;
    logic [7:0]       rate;
    logic [EW-1:0]    step;
    logic [EW-1:0]    acc_x;
    logic [EW-1:0]    sum;
    logic [ACC_W-1:0] tgt;
    logic [EW-1:0]    tgt_step;
    logic [7:0]       vca_d;

    assign rise = gate & ~gate_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            gate_q    <= 1'b0;
            audio_out <= MIDSCALE;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            gate_q    <= gate;
            audio_out <= vca_d;
        end
    end

    always_comb begin
        rate = 8'h00;
        case (state)
            ATTACK:  rate = attack_rate;
            DECAY:   rate = decay_rate;
            RELEASE: rate = release_rate;
            default: rate = 8'h00;
        endcase
    end

    // One extra bit so sums and target+step comparisons never wrap
    assign step     = EW'(rate) + EW'(1);
    assign acc_x    = {1'b0, acc};
    assign sum      = acc_x + step;
    assign tgt      = {sustain_level, {(ACC_W-8){1'b1}}};
    assign tgt_step = {1'b0, tgt} + step;

    always_comb begin
        state_d = state;
        acc_d   = acc;
        if (rise) begin
            state_d = ATTACK;
        end else if (!gate && (state == ATTACK ||
                               state == DECAY  ||
                               state == SUSTAIN)) begin
            state_d = RELEASE;
        end else if (enable) begin
            case (state)
                ATTACK: begin
                    if (sum >= {1'b0, {ACC_W{1'b1}}}) begin
                        acc_d   = '1;
                        state_d = DECAY;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                end
                DECAY: begin
                    if (acc_x <= tgt_step) begin
                        acc_d   = tgt;
                        state_d = SUSTAIN;
                    end else begin
                        acc_d = acc - step[ACC_W-1:0];
                    end
                end
                SUSTAIN: acc_d = tgt;
                RELEASE: begin
                    if (acc_x <= step) begin
                        acc_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = acc - step[ACC_W-1:0];
                    end
                end
                default: acc_d = '0;
            endcase
        end
    end

    assign env_out   = acc[ACC_W-1 -: 8];
    assign env_state = state;
    assign busy      = (state != IDLE);

    vca_scale u_vca (
        .wave      (wave_in),
        .env_level (env_out),
        .scaled    (vca_d)
    );

endmodule

// File: tb/tb_adsr_vca.sv
// Directed scoreboard bench for adsr_vca with ACC_W=10.
module tb_adsr_vca;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       gate;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] sustain_level;
    logic [7:0] release_rate;
    logic [7:0] wave_in;
    logic [7:0] env_out;
    logic [7:0] audio_out;
    logic [2:0] env_state;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] v;
    } exp_t;

    exp_t q[$];

    adsr_vca #(.ACC_W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .wave_in       (wave_in),
        .env_out       (env_out),
        .audio_out     (audio_out),
        .env_state     (env_state),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(string tag, int sel, logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic exp_env(string tag, logic [7:0] env, logic [2:0] st);
        push({tag, ".env"}, 0, env);
        push({tag, ".state"}, 1, {5'd0, st});
        push({tag, ".busy"}, 3, {7'd0, st != 3'd0});
    endtask

    task automatic exp_audio(string tag, logic [7:0] a);
        push({tag, ".audio"}, 2, a);
    endtask

    task automatic tick();
        exp_t       e;
        logic [7:0] obs;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                0:       obs = env_out;
                1:       obs = {5'd0, env_state};
                2:       obs = audio_out;
                default: obs = {7'd0, busy};
            endcase
            compared++;
            assert (obs === e.v) else begin
                mismatched++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    initial begin
        bit reached;
        rst           = 1'b1;
        enable        = 1'b1;
        gate          = 1'b0;
        attack_rate   = 8'h3F;
        decay_rate    = 8'hFF;
        sustain_level = 8'h80;
        release_rate  = 8'h7F;
        wave_in       = 8'h80;

        exp_env("reset", 8'h00, 3'd0);
        exp_audio("reset", 8'h80);
        tick();
        rst = 1'b0;
        exp_env("idle", 8'h00, 3'd0);
        tick();

        gate = 1'b1;
        exp_env("rise", 8'h00, 3'd1);
        tick();
        for (int i = 1; i <= 15; i++) begin
            exp_env($sformatf("atk%0d", i), 8'((64 * i) >> 2), 3'd1);
            tick();
        end
        exp_env("atk16", 8'hFF, 3'd2);
        tick();

        exp_env("dec1", 8'hBF, 3'd2);
        tick();
        exp_env("dec2", 8'h80, 3'd3);
        tick();
        sustain_level = 8'h40;
        exp_env("sus40", 8'h40, 3'd3);
        tick();
        sustain_level = 8'hFF;
        exp_env("susFF", 8'hFF, 3'd3);
        tick();

        wave_in = 8'hFF;
        exp_audio("vca_ff", 8'hFE);
        tick();
        wave_in = 8'h00;
        exp_audio("vca_00", 8'h00);
        tick();
        wave_in = 8'hC0;
        exp_audio("vca_c0", 8'hBF);
        tick();
        wave_in = 8'h80;
        sustain_level = 8'h80;
        exp_audio("vca_80", 8'h80);
        exp_env("sus80", 8'h80, 3'd3);
        tick();
        wave_in = 8'h00;
        exp_audio("vca_half", 8'h40);
        tick();
        wave_in = 8'h80;

        gate = 1'b0;
        exp_env("rel0", 8'h80, 3'd4);
        tick();
        exp_env("rel387", 8'h60, 3'd4);
        tick();
        exp_env("rel259", 8'h40, 3'd4);
        tick();
        exp_env("rel131", 8'h20, 3'd4);
        tick();
        exp_env("rel3", 8'h00, 3'd4);
        tick();
        wave_in = 8'hFF;
        exp_env("rel_end", 8'h00, 3'd0);
        tick();
        exp_audio("vca_env0", 8'h80);
        tick();
        wave_in = 8'h80;

        gate = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            tick();
            if (env_state == 3'd3) reached = 1'b1;
        end
        push("note2_sustain.state", 1, 8'd3);
        tick();
        gate = 1'b0;
        exp_env("rt_rel", 8'h80, 3'd4);
        tick();
        exp_env("rt_387", 8'h60, 3'd4);
        tick();
        exp_env("rt_259", 8'h40, 3'd4);
        tick();
        gate = 1'b1;
        exp_env("retrig", 8'h40, 3'd1);
        tick();
        exp_env("rt_323", 8'h50, 3'd1);
        tick();
        exp_env("rt_387a", 8'h60, 3'd1);
        tick();
        exp_env("rt_451", 8'h70, 3'd1);
        tick();
        exp_env("rt_515", 8'h80, 3'd1);
        tick();

        rst = 1'b1;
        wave_in = 8'hFF;
        exp_env("mid_rst", 8'h00, 3'd0);
        exp_audio("mid_rst", 8'h80);
        tick();
        rst = 1'b0;
        exp_env("post_rst", 8'h00, 3'd1);
        tick();
        exp_env("post_atk", 8'h10, 3'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
